// File: rtl/nibble_serial_adder.sv
// Multi-word adder built around a single 4-bit add stage, processing one nibble
// per clock (least-significant first) with the carry chained between nibbles.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] K_LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] k_q, k_d;
  logic [W-1:0]  s_q, s_d;
  logic          co_q, co_d;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    sum5;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    s_d     = s_q;
    co_d    = co_q;

    // The single 4-bit add stage always works on the nibble selected by k.
    a_nib = a_q[4*int'(k_q) +: 4];
    b_nib = b_q[4*int'(k_q) +: 4];
    sum5  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[4*int'(k_q) +: 4] = sum5[3:0];
        carry_d               = sum5[4];
        if (k_q == K_LAST) begin
          co_d    = sum5[4];
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder for a 4-nibble build and
// a 1-nibble build, with expected values computed in the bench.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        co;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        ci1;
  logic        busy1;
  logic        done1;
  logic [3:0]  s1;
  logic        co1;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .s(s1), .co(co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one addition on the 4-nibble DUT and wait (bounded) for done.
  // lat counts edges after the start edge; busy_cnt counts busy cycles up to done.
  task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                        output logic [15:0] s_o, output logic co_o,
                        output int lat, output int busy_cnt);
    a = av; b = bv; ci = civ; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    s_o = 'x;
    co_o = 1'bx;
    while (lat < 40) begin
      if (busy) busy_cnt++;
      if (done) break;
      tick();
      lat++;
    end
    if (done) begin
      s_o = s;
      co_o = co;
      tick();
    end else begin
      lat = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; ci = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (s !== 16'h0000) begin errors++; $display("[TB] FAIL reset_s: got %h expected 0000", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("[TB] FAIL reset_co: got %b expected 0", co); end
    checks++; if ({busy1, done1, s1, co1} !== 7'b0) begin errors++; $display("[TB] FAIL reset_n1: got %b expected 0", {busy1, done1, s1, co1}); end
  endtask

  task automatic test_basic();
    logic [15:0] so; logic coo; int lat; int bc;
    do_add(16'h1234, 16'h1111, 1'b0, so, coo, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (bc !== 5) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 5", bc); end
    checks++; if (so !== 16'h2345) begin errors++; $display("[TB] FAIL basic_s: got %h expected 2345", so); end
    checks++; if (coo !== 1'b0) begin errors++; $display("[TB] FAIL basic_co: got %b expected 0", coo); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL basic_idle_after: got %b expected 00", {busy, done}); end
    a = 16'hAAAA; b = 16'h5555;
    tick();
    checks++; if (s !== 16'h2345 || co !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold: got %h/%b expected 2345/0", s, co); end
  endtask

  task automatic test_carry();
    logic [15:0] so; logic coo; int lat; int bc;
    do_add(16'hFFFF, 16'h0001, 1'b0, so, coo, lat, bc);
    checks++; if (so !== 16'h0000 || coo !== 1'b1) begin errors++; $display("[TB] FAIL carry_ripple: got %h/%b expected 0000/1", so, coo); end
    do_add(16'hFFFF, 16'hFFFF, 1'b1, so, coo, lat, bc);
    checks++; if (so !== 16'hFFFF || coo !== 1'b1) begin errors++; $display("[TB] FAIL carry_all_ones: got %h/%b expected ffff/1", so, coo); end
    do_add(16'h0F0F, 16'h00F1, 1'b0, so, coo, lat, bc);
    checks++; if (so !== 16'h1000 || coo !== 1'b0) begin errors++; $display("[TB] FAIL carry_mixed: got %h/%b expected 1000/0", so, coo); end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    a = 16'h0005; b = 16'h0003; ci = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (done) begin
        done_at.push_back(cyc);
        checks++; if (s !== 16'h0008 || co !== 1'b0) begin errors++; $display("[TB] FAIL b2b_result: got %h/%b expected 0008/0", s, co); end
      end
    end
    start = 1'b0;
    checks++; if (done_at.size() !== 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_at.size()); end
    else begin
      checks++; if (done_at[0] !== 4 || done_at[1] !== 10 || done_at[2] !== 16) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d expected 4,10,16", done_at[0], done_at[1], done_at[2]); end
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_ignore_start();
    int n; int extra;
    a = 16'h1234; b = 16'h4321; ci = 1'b1; start = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b0;
    tick(); tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_timeout: got done=%b expected 1", done); end
    checks++; if (s !== 16'h5556 || co !== 1'b0) begin errors++; $display("[TB] FAIL ignore_result: got %h/%b expected 5556/0", s, co); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (done) extra++; end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_second_run: got extra=%0d busy=%b expected 0/0", extra, busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] so; logic coo; int lat; int bc; int spurious;
    a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_flags: got %b expected 00", {busy, done}); end
    checks++; if (s !== 16'h0000 || co !== 1'b0) begin errors++; $display("[TB] FAIL midrst_result: got %h/%b expected 0000/0", s, co); end
    spurious = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done || busy) spurious++; end
    checks++; if (spurious !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", spurious); end
    do_add(16'h00FF, 16'h0001, 1'b0, so, coo, lat, bc);
    checks++; if (so !== 16'h0100 || coo !== 1'b0 || lat !== 4) begin errors++; $display("[TB] FAIL midrst_fresh: got %h/%b lat %0d expected 0100/0 lat 4", so, coo, lat); end
  endtask

  task automatic test_single_nibble();
    int lat;
    a1 = 4'd9; b1 = 4'd8; ci1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin tick(); lat++; end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL n1_latency: got %0d expected 1", lat); end
    checks++; if (s1 !== 4'h2 || co1 !== 1'b1) begin errors++; $display("[TB] FAIL n1_result: got %h/%b expected 2/1", s1, co1); end
    tick();
    a1 = 4'd7; b1 = 4'd8; ci1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin tick(); lat++; end
    checks++; if (s1 !== 4'hF || co1 !== 1'b0 || lat !== 1) begin errors++; $display("[TB] FAIL n1_second: got %h/%b lat %0d expected f/0 lat 1", s1, co1, lat); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] av; logic [15:0] bv; logic cv;
    logic [16:0] exp_sum;
    logic [15:0] so; logic coo; int lat; int bc;
    for (int i = 0; i < 200; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      cv = 1'($urandom);
      exp_sum = {1'b0, av} + {1'b0, bv} + {16'b0, cv};
      do_add(av, bv, cv, so, coo, lat, bc);
      checks++;
      if ({coo, so} !== exp_sum) begin
        errors++;
        $display("[TB] FAIL random_%0d: %h+%h+%b got %b/%h expected %b/%h", i, av, bv, cv, coo, so, exp_sum[16], exp_sum[15:0]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_single_nibble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
